// File: rtl/mem_arbiter_if.sv
// Requester-facing handshake bundle for mem_arbiter: both request ports plus
// the shared completion/read-data/busy return path.
interface mem_arbiter_if #(
  parameter int DW = 16,
  parameter int AW = 8
);
  logic          req0, req1;
  logic          wr0, wr1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          done0, done1;
  logic [DW-1:0] rdata;
  logic          busy;

  // requester side
  modport master (
    output req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1,
    input  done0, done1, rdata, busy
  );

  // controller side
  modport slave (
    input  req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1,
    output done0, done1, rdata, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester round-robin controller for a single-port memory with a shared
// tri-state data bus. Each transaction is IDLE -> ACCESS -> RESP.
module mem_arbiter #(
  parameter int DW = 16,
  parameter int W  = 256,
  parameter int AW = $clog2(W)
) (
  input  logic          clock,
  input  logic          reset,
  mem_arbiter_if.slave  cli,
  output logic          mem_re,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  inout  wire  [DW-1:0] mem_data
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t        state, nxt;
  logic          last;     // requester granted most recently
  logic          gnt;      // grant chosen this IDLE cycle
  logic          g_q;      // latched grant for the in-flight transaction
  logic          wr_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q;
  logic          drive;    // controller owns mem_data this cycle

  // Round-robin pick: on contention favour whoever was not granted last.
  always_comb begin
    gnt = cli.req1;
    if (cli.req0 && cli.req1) gnt = ~last;
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  // Next state and all memory/requester outputs; reset forces everything idle
  // combinationally so an ACCESS or RESP cycle under reset has no effect.
  always_comb begin
    nxt       = state;
    cli.busy  = 1'b0;
    cli.done0 = 1'b0;
    cli.done1 = 1'b0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    drive     = 1'b0;
    if (!reset) begin
      cli.busy = (state != IDLE);
      case (state)
        IDLE: if (cli.req0 || cli.req1) nxt = ACCESS;
        ACCESS: begin
          mem_addr = addr_q;
          mem_we   = wr_q;
          mem_re   = ~wr_q;
          drive    = wr_q;
          nxt      = RESP;
        end
        RESP: begin
          cli.done0 = ~g_q;
          cli.done1 = g_q;
          nxt       = IDLE;
        end
        default: nxt = IDLE;
      endcase
    end
  end

  // Transaction latch at grant time, and read-data capture at end of ACCESS.
  always_ff @(posedge clock) begin
    if (reset) begin
      last    <= 1'b1;
      rdata_q <= '0;
    end else begin
      if (state == IDLE && (cli.req0 || cli.req1)) begin
        g_q     <= gnt;
        last    <= gnt;
        wr_q    <= gnt ? cli.wr1    : cli.wr0;
        addr_q  <= gnt ? cli.addr1  : cli.addr0;
        wdata_q <= gnt ? cli.wdata1 : cli.wdata0;
      end
      if (state == ACCESS && !wr_q) rdata_q <= mem_data;
    end
  end

  assign cli.rdata = rdata_q;
  assign mem_data  = drive ? wdata_q : 'z;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester round-robin controller that shares one single-port Memory (DW-wide words, W entries, combinational read, posedge write, shared tri-state data bus).
- Sequences each transaction and owns the Memory's control pins (re, we, addr) and the shared data bus.
- Writes drive the bus only in the access cycle; read data is registered and returned to the granted requester with a one-cycle done pulse.
- Sits between two client FSMs and the Memory instance in the lab datapath.

Parameters:
DW, 16, data word width
W, 256, number of memory words
AW, $clog2(W), address width

Ports:
clock  input  1  system clock, all state on posedge
reset  input  1  synchronous, active-high
req0  input  1  requester 0 transaction request (level)
req1  input  1  requester 1 transaction request (level)
wr0  input  1  requester 0 op: 1 = write, 0 = read
wr1  input  1  requester 1 op: 1 = write, 0 = read
addr0  input  AW  requester 0 address
addr1  input  AW  requester 1 address
wdata0  input  DW  requester 0 write data
wdata1  input  DW  requester 1 write data
done0  output  1  one-cycle completion pulse to requester 0
done1  output  1  one-cycle completion pulse to requester 1
rdata  output  DW  registered read data, valid while doneN=1 after a read
busy  output  1  1 in any state other than IDLE
mem_re  output  1  to Memory re
mem_we  output  1  to Memory we
mem_addr  output  AW  to Memory addr
mem_data  inout  DW (tri)  shared Memory data bus

Behaviour:
- Clock is clock; reset is synchronous and active-high.
- States: IDLE, ACCESS, RESP. Every transaction takes exactly 3 cycles, IDLE -> ACCESS -> RESP -> IDLE.
- IDLE:
  - If any reqN=1, select grant g per the arbitration rule.
  - Latch addr_g, wdata_g, wr_g and g into internal registers; next state ACCESS.
  - Otherwise stay in IDLE.
- Arbitration:
  - 1-bit pointer last, reset value 1, so requester 0 wins the first contention.
  - Both requesting: grant the one that is not last.
  - One requesting: grant it.
  - last <= g on every grant.
- ACCESS:
  - mem_addr = latched address.
  - Write: mem_we=1 and the controller drives mem_data = latched wdata; the Memory commits at the end-of-cycle edge.
  - Read: mem_re=1, the controller drives mem_data to 'z, and rdata <= mem_data at the end-of-cycle edge.
  - Next state RESP.
- RESP:
  - done_g=1 for exactly this cycle; rdata holds the read value (unchanged after a write).
  - Next state IDLE.
- Handshake:
  - Requester holds req, wr, addr and wdata stable from assertion until it sees done.
  - The controller samples them only in IDLE.
  - A requester that keeps req high in the IDLE cycle after its done is treated as issuing a new transaction.
- Bus rules:
  - mem_data is 'z in every state except ACCESS-write.
  - mem_re and mem_we are never both 1.
  - Both are 0 outside ACCESS.
  - mem_addr is 0 outside ACCESS.
- Reset:
  - Synchronous; next state IDLE; last <= 1; rdata <= 0.
  - Reset values: done0=done1=0, busy=0, mem_re=mem_we=0, mem_addr=0, mem_data='z.
  - mem_re and mem_we are gated combinationally with !reset. A write whose ACCESS cycle has reset=1 does not commit, and the bus is released in that cycle.
  - Reset in RESP suppresses done.
- Requests arriving while busy=1 are not lost. They wait, with req held, until the next IDLE.
- Address range is 0..W-1; no wrap or bounds logic; W is a power of two.

Test Plan:
1. reset 2 cycles, then req0=1, wr0=1, addr0=8'h10, wdata0=16'hBEEF -> mem_we=1 and mem_data=16'hBEEF in cycle 2; done0=1 in cycle 3; busy 1 for cycles 2-3.
2. After test 1, req1=1, wr1=0, addr1=8'h10 -> mem_re=1 in ACCESS, mem_data undriven by the controller; done1=1 with rdata=16'hBEEF.
3. From reset, req0=req1=1 held, both reads, re-asserted after each done -> grants alternate 0,1,0,1; done pulses spaced 3 cycles apart; done0 first.
4. Write 16'h1234 to addr 5, then begin write 16'hFFFF to addr 5 with reset=1 during its ACCESS cycle -> mem_we=0 that cycle, FSM in IDLE, no done; a subsequent read of addr 5 returns 16'h1234.
5. Throughout tests 1-4, check each cycle: mem_re&mem_we never 1; mem_data is 'z whenever not ACCESS-write; done0&done1 never 1.
6. Only req1 asserted repeatedly, with last=1 -> requester 1 granted every time with no starvation; done1 every 3 cycles.
